// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element table for the SRAM March BIST.
//   state_e     : controller FSM states
//   elem_t      : per-element sweep direction, op count, read and write values
//   elem_info() : element index -> table entry
package sram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int unsigned NUM_ELEMS = 6;
  localparam int unsigned ELEM_W    = 3;

  // One March element. If has_read is set, op 0 is the read and op 1 the write.
  typedef struct packed {
    logic       down;
    logic [1:0] n_ops;
    logic       has_read;
    logic       rval;
    logic       wval;
  } elem_t;

  localparam elem_t MARCH_E0 = '{down: 1'b0, n_ops: 2'd1, has_read: 1'b0, rval: 1'b0, wval: 1'b0};
  localparam elem_t MARCH_E1 = '{down: 1'b0, n_ops: 2'd2, has_read: 1'b1, rval: 1'b0, wval: 1'b1};
  localparam elem_t MARCH_E2 = '{down: 1'b0, n_ops: 2'd2, has_read: 1'b1, rval: 1'b1, wval: 1'b0};
  localparam elem_t MARCH_E3 = '{down: 1'b1, n_ops: 2'd2, has_read: 1'b1, rval: 1'b0, wval: 1'b1};
  localparam elem_t MARCH_E4 = '{down: 1'b1, n_ops: 2'd2, has_read: 1'b1, rval: 1'b1, wval: 1'b0};
  localparam elem_t MARCH_E5 = '{down: 1'b0, n_ops: 2'd1, has_read: 1'b1, rval: 1'b0, wval: 1'b0};

  function automatic elem_t elem_info(logic [ELEM_W-1:0] idx);
    elem_t e;
    case (idx)
      3'd0:    e = MARCH_E0;
      3'd1:    e = MARCH_E1;
      3'd2:    e = MARCH_E2;
      3'd3:    e = MARCH_E3;
      3'd4:    e = MARCH_E4;
      3'd5:    e = MARCH_E5;
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sram_bist_if.sv
// SRAM pin bundle between the BIST controller and a single-port sram22 macro.
//   we/wmask/addr/din : controller -> SRAM
//   dout              : SRAM -> controller, valid the cycle after the read edge
// master = BIST controller side, slave = SRAM side.
interface sram_bist_if #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WMASK_WIDTH = 1
);

  logic                   we;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic [DATA_WIDTH-1:0]  dout;

  modport master (output we, wmask, addr, din, input dout);
  modport slave  (input we, wmask, addr, din, output dout);

endinterface

// File: rtl/sram_bist_cmp.sv
// Read-tag pipeline and comparator.
//   launch_i/addr_i/expect_i : read presented to the SRAM this cycle
//   flush_i                  : drop the tag being launched
//   dout_i                   : SRAM read data, aligned with the registered tag
//   mismatch_c_o             : tag valid and dout differs from expected (combinational)
//   addr_o/expect_o          : captured tag; data_c_o mirrors dout_i
module sram_bist_cmp #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  launch_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] expect_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
  output logic                  mismatch_c_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_c_o,
  output logic [DATA_WIDTH-1:0] expect_o
);

  logic                  tag_vld_q;
  logic [ADDR_WIDTH-1:0] tag_addr_q;
  logic [DATA_WIDTH-1:0] tag_exp_q;

  // Tag follows the read by one cycle so it lines up with dout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld_q  <= 1'b0;
      tag_addr_q <= '0;
      tag_exp_q  <= '0;
    end else begin
      tag_vld_q  <= launch_i & ~flush_i;
      tag_addr_q <= addr_i;
      tag_exp_q  <= expect_i;
    end
  end

  assign mismatch_c_o = tag_vld_q && (dout_i != tag_exp_q);
  assign addr_o       = tag_addr_q;
  assign expect_o     = tag_exp_q;
  assign data_c_o     = dout_i;

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller for one single-port SRAM.
//   clk, rst_n (sync, active-low)
//   start                            : one-cycle request, accepted in IDLE/DONE
//   busy/done/fail                   : run status; done and fail are sticky
//   fail_addr/fail_data/fail_expect  : first failing read
//   sram                             : SRAM pin bundle (master side)
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WMASK_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [DATA_WIDTH-1:0] fail_expect,
  sram_bist_if.master           sram
);

  state_e                 state_q;
  logic [ELEM_W-1:0]      elem_q, elem_d;
  logic                   op_q, op_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   we_q, we_d;
  logic [WMASK_WIDTH-1:0] wmask_q;
  logic [DATA_WIDTH-1:0]  din_q, din_d;
  logic                   busy_q, done_q, fail_q;
  logic [ADDR_WIDTH-1:0]  fail_addr_q;
  logic [DATA_WIDTH-1:0]  fail_data_q, fail_exp_q;

  elem_t                  info_q, info_d;
  logic                   last_op, last_addr, run_end;
  logic [DATA_WIDTH-1:0]  expect_c;

  logic                   mismatch_c;
  logic [ADDR_WIDTH-1:0]  cmp_addr;
  logic [DATA_WIDTH-1:0]  cmp_data, cmp_exp;

  // Next-op sequencer: elem_q/op_q/addr_q always describe the op on the pins.
  always_comb begin
    info_q    = elem_info(elem_q);
    last_op   = op_q || (info_q.n_ops == 2'd1);
    last_addr = info_q.down ? (addr_q == '0) : (addr_q == '1);
    run_end   = last_op && last_addr && (elem_q == ELEM_W'(NUM_ELEMS - 1));
    elem_d    = elem_q;
    op_d      = 1'b0;
    addr_d    = addr_q;
    if (!last_op) begin
      op_d = 1'b1;
    end else if (!last_addr) begin
      addr_d = info_q.down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
    end else begin
      elem_d = elem_q + ELEM_W'(1);
      addr_d = elem_info(elem_d).down ? '1 : '0;
    end
    info_d   = elem_info(elem_d);
    we_d     = op_d || !info_d.has_read;
    din_d    = (we_d && info_d.wval) ? '1 : '0;
    expect_c = info_q.rval ? '1 : '0;
  end

  sram_bist_cmp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .clk          (clk),
    .rst_n        (rst_n),
    .launch_i     ((state_q == ST_RUN) && !we_q),
    .flush_i      (mismatch_c),
    .addr_i       (addr_q),
    .expect_i     (expect_c),
    .dout_i       (sram.dout),
    .mismatch_c_o (mismatch_c),
    .addr_o       (cmp_addr),
    .data_c_o     (cmp_data),
    .expect_o     (cmp_exp)
  );

  // Controller FSM with registered SRAM pins and sticky results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wmask_q     <= '0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_exp_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_RUN;
            elem_q      <= '0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b1;
            wmask_q     <= '1;
            din_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_exp_q  <= '0;
          end
        end
        ST_RUN: begin
          if (mismatch_c || run_end) begin
            // Park the SRAM pins; a mismatch ends the run right here.
            state_q <= mismatch_c ? ST_DONE : ST_DRAIN;
            we_q    <= 1'b0;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            if (mismatch_c) begin
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              fail_q      <= 1'b1;
              fail_addr_q <= cmp_addr;
              fail_data_q <= cmp_data;
              fail_exp_q  <= cmp_exp;
            end
          end else begin
            elem_q  <= elem_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wmask_q <= we_d ? '1 : '0;
            din_q   <= din_d;
          end
        end
        ST_DRAIN: begin
          // Last E5 read is compared here.
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (mismatch_c) begin
            fail_q      <= 1'b1;
            fail_addr_q <= cmp_addr;
            fail_data_q <= cmp_data;
            fail_exp_q  <= cmp_exp;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;
  assign fail_expect = fail_exp_q;
  assign sram.we     = we_q;
  assign sram.wmask  = wmask_q;
  assign sram.addr   = addr_q;
  assign sram.din    = din_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural 16x8 SRAM with optional faults, a
// reference March C- model feeding an op-trace scoreboard, and result checks.
module tb_sram_march_bist;

  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned WMW = 1;
  localparam int          D   = 1 << AW;
  localparam int          N   = 10 * D;
  localparam int          OPW = AW + DW + 2;

  typedef logic [OPW-1:0] op_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data, fail_expect;

  sram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(WMW)) sram_bus ();

  sram_march_bist #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .WMASK_WIDTH (WMW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data),
    .fail_expect (fail_expect),
    .sram        (sram_bus.master)
  );

  always #5 clk = ~clk;

  int checks      = 0;
  int failures    = 0;
  int busy_cycles = 0;
  int fault_mode  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural SRAM. Mode 1: addr 5 bit 3 stuck at 0. Mode 2: writing ones
  // to addr 9 forces addr 8 to ones.
  logic [DW-1:0] mem [D];
  always @(posedge clk) begin
    if (sram_bus.we) begin
      if (sram_bus.wmask[0]) begin
        if (fault_mode == 1 && sram_bus.addr == AW'(5))
          mem[sram_bus.addr] <= sram_bus.din & 8'hF7;
        else
          mem[sram_bus.addr] <= sram_bus.din;
        if (fault_mode == 2 && sram_bus.addr == AW'(9) && sram_bus.din == 8'hFF)
          mem[8] <= 8'hFF;
      end
      sram_bus.dout <= DW'($urandom);
    end else begin
      sram_bus.dout <= mem[sram_bus.addr];
    end
  end

  // Scoreboard of expected ops and expected result registers.
  op_t           exp_q[$];
  int            exp_busy;
  logic          exp_fail;
  logic [AW-1:0] exp_faddr;
  logic [DW-1:0] exp_fdata, exp_fexp;

  function automatic op_t pack_op(logic we, logic wm, logic [AW-1:0] a, logic [DW-1:0] d);
    return {we, we ? wm : 1'b0, a, we ? d : DW'(0)};
  endfunction

  task automatic build_expect(input int fmode);
    logic          ow [N];
    logic [AW-1:0] oa [N];
    logic [DW-1:0] od [N];
    logic [DW-1:0] mm [D];
    int n, a, last, fidx;
    logic rv, wv;
    n = 0;
    for (int e = 0; e < 6; e++) begin
      for (int s = 0; s < D; s++) begin
        a  = (e == 3 || e == 4) ? D - 1 - s : s;
        rv = (e == 2 || e == 4);
        wv = (e == 1 || e == 3);
        if (e != 0) begin ow[n] = 1'b0; oa[n] = AW'(a); od[n] = rv ? 8'hFF : 8'h00; n++; end
        if (e != 5) begin ow[n] = 1'b1; oa[n] = AW'(a); od[n] = wv ? 8'hFF : 8'h00; n++; end
      end
    end
    for (int i = 0; i < D; i++) mm[i] = 8'h00;
    exp_fail = 1'b0; exp_faddr = '0; exp_fdata = '0; exp_fexp = '0;
    last = N - 1; fidx = -1;
    for (int i = 0; i < N; i++) begin
      if (ow[i]) begin
        mm[oa[i]] = (fmode == 1 && oa[i] == AW'(5)) ? (od[i] & 8'hF7) : od[i];
        if (fmode == 2 && oa[i] == AW'(9) && od[i] == 8'hFF) mm[8] = 8'hFF;
      end else if (mm[oa[i]] != od[i]) begin
        exp_fail  = 1'b1;
        exp_faddr = oa[i];
        exp_fdata = mm[oa[i]];
        exp_fexp  = od[i];
        fidx      = i;
        last      = (i + 1 < N) ? i + 1 : i;
        break;
      end
    end
    exp_busy = exp_fail ? fidx + 2 : N + 1;
    exp_q.delete();
    for (int i = 0; i <= last; i++) exp_q.push_back(pack_op(ow[i], 1'b1, oa[i], od[i]));
  endtask

  // Op monitor: one presented op per busy cycle, then the drain cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        busy_cycles++;
        if (exp_q.size() > 0)
          check("op", 32'(pack_op(sram_bus.we, sram_bus.wmask[0], sram_bus.addr, sram_bus.din)),
                32'(exp_q.pop_front()));
        else
          check("drain_idle", 32'({sram_bus.we, sram_bus.wmask, sram_bus.addr, sram_bus.din}), 32'd0);
      end else if (sram_bus.we) begin
        check("we_idle", 32'(sram_bus.we), 32'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_status"}, 32'({busy, done, fail}), 32'd0);
    check({tag, "_fail_regs"}, 32'({fail_addr, fail_data, fail_expect}), 32'd0);
    check({tag, "_sram"}, 32'({sram_bus.we, sram_bus.wmask, sram_bus.addr, sram_bus.din}), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_test(input string name, input int fmode, input bit extra_starts);
    bit got;
    build_expect(fmode);
    fault_mode  = fmode;
    busy_cycles = 0;
    pulse_start();
    check({name, "_busy_on"}, 32'(busy), 32'd1);
    check({name, "_clr"}, 32'({done, fail, fail_addr, fail_data, fail_expect}), 32'd0);
    got = 1'b0;
    for (int c = 1; c < 400; c++) begin
      start = extra_starts && (c == 3 || c == 50);
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    start = 1'b0;
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
    check({name, "_busy_off"}, 32'(busy), 32'd0);
    check({name, "_fail"}, 32'(fail), 32'(exp_fail));
    check({name, "_fail_addr"}, 32'(fail_addr), 32'(exp_faddr));
    check({name, "_fail_data"}, 32'(fail_data), 32'(exp_fdata));
    check({name, "_fail_expect"}, 32'(fail_expect), 32'(exp_fexp));
    check({name, "_ops_left"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check({name, "_done_sticky"}, 32'(done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Start held through the last reset edge must not launch a run.
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("start_in_reset", 32'(busy), 32'd0);

    run_test("pass", 0, 1'b0);
    run_test("ignstart", 0, 1'b1);
    run_test("stuck", 1, 1'b0);
    run_test("b2b", 0, 1'b0);
    run_test("coupling", 2, 1'b0);

    // Reset in the middle of a run.
    build_expect(0);
    fault_mode = 0;
    pulse_start();
    repeat (69) @(negedge clk);
    check("midrun_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrun_rst");
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    run_test("after_rst", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
